// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: decode-side valid/ready instruction port of fetch_buffer
interface fetch_buffer_if #(
    parameter int i_addr_bits = 6
);
    logic                   inst_valid;
    logic                   inst_ready;
    logic [31:0]            inst_data;
    logic [i_addr_bits-1:0] inst_pc;
    modport master (output inst_valid, inst_data, inst_pc, input inst_ready);
    modport slave (input inst_valid, inst_data, inst_pc, output inst_ready);
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction prefetch with credit-based issue and a PC-tagged FIFO
// Optional FETCH_MISALIGN_EN: adds fetch_misalign and blocks issue after a misaligned redirect.
module fetch_buffer #(
    parameter int i_addr_bits = 6,
    parameter int DEPTH       = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [i_addr_bits-1:0]  i_mem_addr,
    input  logic [31:0]             i_mem_data,
    input  logic                    redirect,
    input  logic [i_addr_bits-1:0]  redirect_pc,
    fetch_buffer_if.master          dec,
    output logic [$clog2(DEPTH):0]  occupancy
`ifdef FETCH_MISALIGN_EN
    ,
    output logic                    fetch_misalign
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    typedef enum logic {STARTUP, RUN} state_t;
    state_t                 state_q, state_d;
    logic [i_addr_bits-1:0] fetch_pc, inflight_pc, load_pc;
    logic                   inflight, issue, push, pop, blocked;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic [31:0]            mem_data [DEPTH];
    logic [i_addr_bits-1:0] mem_pc [DEPTH];
`ifdef FETCH_MISALIGN_EN
    logic misalign;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign <= 1'b0;
        else if (redirect)
            misalign <= |redirect_pc[1:0];
    end
    assign fetch_misalign = misalign;
    assign blocked        = misalign;
    assign load_pc        = redirect_pc;
`else
    assign blocked = 1'b0;
    assign load_pc = redirect_pc & ~i_addr_bits'(3);
`endif
    // Credits cover both queued entries and the word still in the memory pipe.
    always_comb begin
        state_d = RUN;
        pop     = dec.inst_valid && dec.inst_ready;
        push    = inflight && !redirect;
        issue   = state_q == RUN && !redirect && !blocked && (count + CW'(inflight)) < CW'(DEPTH);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= STARTUP;
            fetch_pc    <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + i_addr_bits'(4);
            end
            if (redirect) begin
                fetch_pc <= load_pc;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    mem_data[wr_ptr] <= i_mem_data;
                    mem_pc[wr_ptr]   <= inflight_pc;
                    wr_ptr           <= wr_ptr + PW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
    assign i_mem_addr     = fetch_pc;
    assign occupancy      = count;
    assign dec.inst_valid = count != '0;
    assign dec.inst_data  = mem_data[rd_ptr];
    assign dec.inst_pc    = mem_pc[rd_ptr];
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed stimulus with a queue-based scoreboard on the decode handshake
module tb_fetch_buffer;
    localparam int AW = 6;
    localparam int D  = 4;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               redirect = 1'b0;
    logic [AW-1:0]      redirect_pc = '0;
    logic [AW-1:0]      i_mem_addr;
    logic [31:0]        i_mem_data = '0;
    logic [$clog2(D):0] occupancy;
`ifdef FETCH_MISALIGN_EN
    logic               fetch_misalign;
`endif
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] mon_e;

    fetch_buffer_if #(.i_addr_bits(AW)) dif ();

    fetch_buffer #(.i_addr_bits(AW), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_mem_addr (i_mem_addr),
        .i_mem_data (i_mem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .dec        (dif),
        .occupancy  (occupancy)
`ifdef FETCH_MISALIGN_EN
        ,
        .fetch_misalign(fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: word at byte address a is 0xA0000000 + a.
    always @(posedge clk) i_mem_data <= 32'hA000_0000 + 32'(i_mem_addr);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic go(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic hold_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", dif.inst_valid, 0);
        chk("reset_occ", occupancy, 0);
        chk("reset_addr", i_mem_addr, 0);
        chk("reset_pc", dif.inst_pc, 0);
        chk("reset_data", dif.inst_data, 0);
`ifdef FETCH_MISALIGN_EN
        chk("reset_misalign", fetch_misalign, 0);
`endif
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n && dif.inst_valid && dif.inst_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output pc=%0h data=%0h expected=none", dif.inst_pc, dif.inst_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("stream_pc", dif.inst_pc, mon_e);
                chk("stream_data", dif.inst_data, 32'hA000_0000 + 32'(mon_e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Startup latency, redirect flush, wrap-around
        dif.inst_ready = 1'b1;
        exp_q = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h20, 6'h24, 6'h28, 6'h3C, 6'h00, 6'h04};
        hold_reset();
        mid(); chk("startup_addr", i_mem_addr, 0);
        go(2); mid(); chk("c2_valid", dif.inst_valid, 0);
        go(3); mid(); chk("c3_valid", dif.inst_valid, 1);
        go(6); redirect = 1'b1; redirect_pc = 6'h20;
        go(7); redirect = 1'b0;
        mid(); chk("redir_occ", occupancy, 0); chk("redir_addr", i_mem_addr, 6'h20);
        go(8); mid(); chk("redir_c8_valid", dif.inst_valid, 0);
        go(9); mid(); chk("redir_c9_valid", dif.inst_valid, 1);
        go(11); redirect = 1'b1; redirect_pc = 6'h3C;
        go(12); redirect = 1'b0;
        mid(); chk("redir2_addr", i_mem_addr, 6'h3C);
        go(13); mid(); chk("addr_wrap", i_mem_addr, 6'h00);
        go(17); dif.inst_ready = 1'b0;
        chk("phase_a_drained", exp_q.size(), 0);
        // Backpressure until full, then drain without gaps
        hold_reset();
        go(5); mid(); chk("stall_addr_c5", i_mem_addr, 6'h10);
        go(11); mid();
        chk("full_occ", occupancy, 4); chk("full_addr", i_mem_addr, 6'h10);
        chk("full_valid", dif.inst_valid, 1); chk("full_head", dif.inst_pc, 6'h00);
        go(12); exp_q = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14}; dif.inst_ready = 1'b1;
        go(15); chk("no_gap", exp_q.size(), 3);
        go(18); dif.inst_ready = 1'b0;
        chk("phase_b_drained", exp_q.size(), 0);
        // Asynchronous reset mid-cycle with three queued entries
        hold_reset();
        go(5); mid(); chk("pre_reset_occ", occupancy, 3);
        #2; rst_n = 1'b0; #1;
        chk("async_valid", dif.inst_valid, 0); chk("async_occ", occupancy, 0); chk("async_addr", i_mem_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; cyc = 0; dif.inst_ready = 1'b1;
        exp_q = '{6'h00, 6'h04};
        go(2); mid(); chk("restart_c2_valid", dif.inst_valid, 0);
        go(5); dif.inst_ready = 1'b0;
        chk("phase_e_drained", exp_q.size(), 0);
`ifdef FETCH_MISALIGN_EN
        go(6); redirect = 1'b1; redirect_pc = 6'h22;
        go(7); redirect = 1'b0; dif.inst_ready = 1'b1;
        mid(); chk("misalign_set", fetch_misalign, 1); chk("misalign_occ", occupancy, 0);
        for (int i = 8; i <= 14; i++) begin
            go(i); mid(); chk("misalign_blocked", dif.inst_valid, 0);
        end
        go(15); redirect = 1'b1; redirect_pc = 6'h24; exp_q = '{6'h24};
        go(16); redirect = 1'b0;
        mid(); chk("misalign_clear", fetch_misalign, 0); chk("realign_addr", i_mem_addr, 6'h24);
        go(18); mid(); chk("realign_valid", dif.inst_valid, 1);
        go(19); dif.inst_ready = 1'b0;
        chk("phase_f_drained", exp_q.size(), 0);
`else
        go(6); redirect = 1'b1; redirect_pc = 6'h22; exp_q = '{6'h20};
        go(7); redirect = 1'b0; dif.inst_ready = 1'b1;
        mid(); chk("align_force_addr", i_mem_addr, 6'h20);
        go(9); mid(); chk("align_valid", dif.inst_valid, 1);
        go(10); dif.inst_ready = 1'b0;
        chk("phase_f_drained", exp_q.size(), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction prefetch stage between the instruction memory (`Memoria` instruction port) and the decode stage of the `polirv` core.
- Owns the fetch PC and drives `i_mem_addr`.
- Captures `i_mem_data` under a one-cycle synchronous-read latency and queues fetched words with their PCs in a small FIFO.
- Presents the queue to decode through a valid/ready handshake; a redirect (branch/jump) flushes it and restarts fetch.

Parameters:
- i_addr_bits, 6: width of the instruction byte address and of the PC.
- DEPTH, 4: FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- i_mem_addr  output  i_addr_bits  instruction memory byte address; the memory samples it at the rising edge.
- i_mem_data  input  32  instruction word, valid the cycle after its address was sampled.
- redirect  input  1  flush request; load a new PC.
- redirect_pc  input  i_addr_bits  target PC, used when redirect=1.
- inst_valid  output  1  FIFO head holds a valid instruction.
- inst_ready  input  1  decode accepts the head this cycle.
- inst_data  output  32  head instruction word.
- inst_pc  output  i_addr_bits  byte PC of the head instruction.
- occupancy  output  $clog2(DEPTH)+1  number of valid FIFO entries.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n). Reset clears all state regardless of clock.
- Reset values:
  - fetch_pc=0 and i_mem_addr=0.
  - inst_valid=0, inst_data=0, inst_pc=0, occupancy=0.
  - inflight=0 and all FIFO pointers at 0.
- i_mem_addr is driven directly from the fetch_pc register. The memory has no enable, so issue is tracked internally.
- Issue condition: occupancy + inflight < DEPTH, redirect=0, and not in STARTUP. The condition is credit-based, so the FIFO can never overflow.
- On issue:
  - inflight<=1; inflight_pc<=fetch_pc.
  - fetch_pc<=fetch_pc+4, wrapping modulo 2^i_addr_bits.
- When no issue occurs, fetch_pc holds and inflight<=0.
- Capture: when inflight=1 and no redirect this cycle, {i_mem_data, inflight_pc} is written at the FIFO tail at the end of the cycle.
- Pop: inst_valid & inst_ready pops the head at the end of the cycle. Push and pop in the same cycle leave occupancy unchanged. A pop while empty is ignored.
- inst_valid = (occupancy != 0). inst_data and inst_pc are registered FIFO outputs and are stable while inst_valid=1 and inst_ready=0.
- FSM, one state register:
  - STARTUP: the first cycle after reset release; i_mem_addr=0 is presented but not counted as an issue. Always moves to RUN.
  - RUN: normal issue/capture.
  - There is no other state; a stall is RUN with the issue condition false.
- Redirect (highest priority, any state):
  - The FIFO is emptied and any inflight capture is discarded (inflight<=0).
  - fetch_pc<=redirect_pc; no issue occurs this cycle.
  - A handshake in the same cycle counts as accepted by decode, but the entry is flushed with the rest.
  - The state goes to RUN.
- Latency: redirect asserted in cycle N gives i_mem_addr=redirect_pc in N+1, capture at the end of N+2, and inst_valid=1 with inst_pc=redirect_pc in N+3. After reset release (cycle 0 = STARTUP), the first inst_valid appears in cycle 3 with inst_pc=0.
- Steady state with inst_ready=1 continuously: one instruction per cycle, PCs 0,4,8,...
- Wrap-around: fetch_pc = 2^i_addr_bits-4 is followed by 0 with no flag. FIFO pointers wrap modulo DEPTH.
- Full: occupancy=DEPTH holds inst_valid=1 and issues nothing. The cycle after a pop, fetch resumes at the next sequential PC; no PC is skipped or duplicated.
- Reset mid-operation: everything returns to reset values immediately, and inflight data is never captured.

Optional Feature:
- FETCH_MISALIGN_EN defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1 in the next cycle, flushes as normal, and then blocks all issue.
  - fetch_misalign stays 1 until a redirect with an aligned PC clears it; that redirect also restarts fetch normally.
- FETCH_MISALIGN_EN undefined:
  - No extra port.
  - redirect_pc[1:0] is ignored and forced to 00 when loaded into fetch_pc.

Test Plan:
- Memory word at byte address a holds 0xA0000000+a. Release reset with inst_ready=1. Required: inst_valid first high in cycle 3 with inst_pc=0x00 and inst_data=0xA0000000, then 0x04/0xA0000004 and 0x08/0xA0000008 on consecutive cycles.
- Hold inst_ready=0 for 10 cycles. Required: occupancy saturates at 4; i_mem_addr freezes at 0x10; head stays 0x00. Raising inst_ready yields PCs 0x00,0x04,0x08,0x0C,0x10,0x14 with no gap or duplicate.
- In steady state, pulse redirect=1 with redirect_pc=0x20. Required: occupancy=0 the next cycle; i_mem_addr=0x20 the next cycle; inst_valid reappears 3 cycles after the redirect cycle with inst_pc=0x20 and inst_data=0xA0000020. The stale inflight word is never output.
- Redirect to 0x3C, inst_ready=1. Required: output PC sequence 0x3C, 0x00, 0x04 (wrap).
- Assert rst_n=0 asynchronously mid-cycle with occupancy=3. Required: inst_valid=0 and occupancy=0 immediately; after release, the stream restarts at PC 0x00.
- With FETCH_MISALIGN_EN, redirect to 0x22. Required: fetch_misalign=1 and no inst_valid for 8 cycles. A following redirect to 0x24 clears fetch_misalign and outputs PC 0x24.
